// File: rtl/edge_detect_top.sv
// edge_detect_top: RGB->gray input FIFO, streaming 3x3 Sobel with two line buffers, output FIFO.
// Output for pixel p is emitted once pixel p+IMAGE_WIDTH+1 is consumed; each frame ends with a zero-input flush.
module edge_detect_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  always_comb begin
    empty = cnt == '0;
    full = cnt == (AW+1)'(DEPTH);
    do_push = push && !full;
    do_pop = pop && !empty;
    dout = empty ? '0 : mem[rp];
  end
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module edge_detect_top #(
  parameter int DATA_WIDTH = 8,
  parameter int IMAGE_WIDTH = 720,
  parameter int IMAGE_HEIGHT = 540
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_inputs,
  input  logic [DATA_WIDTH-1:0] red_in,
  input  logic [DATA_WIDTH-1:0] green_in,
  input  logic [DATA_WIDTH-1:0] blue_in,
  output logic                  fifo_in_gray_full,
  input  logic                  rd_output,
  output logic                  out_empty,
  output logic [DATA_WIDTH-1:0] data_out
);
  localparam int N = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int KW = $clog2(N + IMAGE_WIDTH + 1);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam logic [11:0] SAT = 12'd255;
  function automatic logic signed [11:0] ext(input logic [DATA_WIDTH-1:0] v);
    return $signed({{(12-DATA_WIDTH){1'b0}}, v});
  endfunction
  logic [DATA_WIDTH+1:0] sum;
  logic [DATA_WIDTH-1:0] gray, pix, x, top, mid, out_val;
  logic [DATA_WIDTH-1:0] a0, a1, a2, b0, b1, b2;
  logic [DATA_WIDTH-1:0] lb0 [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMAGE_WIDTH];
  logic [KW-1:0] k;
  logic [CW-1:0] col, ocol;
  logic [RW-1:0] orow;
  logic in_empty, out_full, dummy, adv, push_out, border, last;
  logic signed [11:0] gx, gy;
  logic [11:0] ax, ay, half;
  edge_detect_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(32)) u_in (
    .clk(clk), .rst(rst), .push(wr_inputs), .din(gray), .pop(adv && !dummy),
    .dout(pix), .empty(in_empty), .full(fifo_in_gray_full)
  );
  edge_detect_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(32)) u_out (
    .clk(clk), .rst(rst), .push(push_out), .din(out_val), .pop(rd_output),
    .dout(data_out), .empty(out_empty), .full(out_full)
  );
  always_comb begin
    sum = {2'b00, red_in} + {2'b00, green_in} + {2'b00, blue_in};
    gray = DATA_WIDTH'(sum / (DATA_WIDTH+2)'(3));
    dummy = k >= KW'(N);
    last = k == KW'(N + IMAGE_WIDTH);
    adv = (dummy || !in_empty) && !out_full;
    push_out = adv && k > KW'(IMAGE_WIDTH);
    x = dummy ? '0 : pix;
    top = lb1[col];
    mid = lb0[col];
    gx = ext(top) + (ext(mid) <<< 1) + ext(x) - ext(a0) - (ext(a1) <<< 1) - ext(a2);
    gy = ext(a2) + (ext(b2) <<< 1) + ext(x) - ext(a0) - (ext(b0) <<< 1) - ext(top);
    ax = gx[11] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[11] ? $unsigned(-gy) : $unsigned(gy);
    half = (ax + ay) >> 1;
    border = orow == '0 || orow == RW'(IMAGE_HEIGHT-1) || ocol == '0 || ocol == CW'(IMAGE_WIDTH-1);
    out_val = border ? '0 : DATA_WIDTH'(half > SAT ? SAT : half);
  end
  always_ff @(posedge clk) begin
    if (adv) begin
      lb0[col] <= x;
      lb1[col] <= mid;
    end
  end
  // Window columns: a = centre column - 1, b = centre column; the incoming column is combinational.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {a0, a1, a2, b0, b1, b2} <= '0;
      k <= '0;
      col <= '0;
      ocol <= '0;
      orow <= '0;
    end else begin
      if (adv) begin
        {a0, a1, a2} <= {b0, b1, b2};
        {b0, b1, b2} <= {top, mid, x};
        k <= last ? '0 : k + 1'b1;
        col <= (last || col == CW'(IMAGE_WIDTH-1)) ? '0 : col + 1'b1;
      end
      if (push_out) begin
        ocol <= ocol == CW'(IMAGE_WIDTH-1) ? '0 : ocol + 1'b1;
        if (ocol == CW'(IMAGE_WIDTH-1)) orow <= orow == RW'(IMAGE_HEIGHT-1) ? '0 : orow + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_edge_detect_top.sv
// tb_edge_detect_top: random and directed frames on a 4x4 image against a queue-based Sobel model.
module tb_edge_detect_top;
  localparam int W = 4, H = 4, N = W * H;
  logic clk = 0, rst = 0, wr_inputs = 0, rd_output = 0;
  logic [7:0] red_in = 0, green_in = 0, blue_in = 0, data_out;
  logic fifo_in_gray_full, out_empty;
  int n_cmp = 0, n_bad = 0, nout = 0, cur_mode = 0;
  int pix[$];
  int pmode[$];
  edge_detect_top #(.DATA_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .wr_inputs(wr_inputs), .red_in(red_in), .green_in(green_in),
    .blue_in(blue_in), .fifo_in_gray_full(fifo_in_gray_full), .rd_output(rd_output),
    .out_empty(out_empty), .data_out(data_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit is_border(int j);
    int p = j % N;
    return p / W == 0 || p / W == H - 1 || p % W == 0 || p % W == W - 1;
  endfunction
  function automatic int golden(int j);
    int b = (j / N) * N, r = (j % N) / W, c = (j % N) % W;
    int t[3][3];
    int gx, gy, m;
    if (is_border(j)) return 0;
    if (b + (r + 1) * W + c + 1 >= pix.size()) return -1;
    for (int i = 0; i < 3; i++)
      for (int e = 0; e < 3; e++) t[i][e] = pix[b + (r + i - 1) * W + c + e - 1];
    gx = t[0][2] + 2 * t[1][2] + t[2][2] - t[0][0] - 2 * t[1][0] - t[2][0];
    gy = t[2][0] + 2 * t[2][1] + t[2][2] - t[0][0] - 2 * t[0][1] - t[0][2];
    m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
    return m > 255 ? 255 : m;
  endfunction
  function automatic logic [23:0] rgb(int mode, int idx);
    int c = idx % W;
    case (mode)
      1: return {8'd30, 8'd60, 8'd90};
      2: return c < 2 ? 24'h0 : 24'hFFFFFF;
      3: return c < 2 ? 24'h0 : {8'd40, 8'd40, 8'd40};
      default: return 24'($urandom);
    endcase
  endfunction
  task automatic step(input bit wr, input logic [23:0] px, input bit rd, output bit acc);
    int dexp;
    @(negedge clk);
    wr_inputs = wr;
    {red_in, green_in, blue_in} = px;
    rd_output = rd;
    acc = wr && !fifo_in_gray_full;
    if (acc) begin
      pix.push_back((int'(px[23:16]) + int'(px[15:8]) + int'(px[7:0])) / 3);
      pmode.push_back(cur_mode);
    end
    if (rd && !out_empty) begin
      check("sobel", 32'(data_out), 32'(golden(nout)));
      if (pmode[nout] != 0) begin
        dexp = is_border(nout) ? 0 : pmode[nout] == 2 ? 255 : pmode[nout] == 3 ? 80 : 0;
        check("directed", 32'(data_out), 32'(dexp));
      end
      nout++;
    end
  endtask
  task automatic write_frames(input int nf, input int mode, input int wr_pct, input int rd_pct);
    bit acc;
    int tries;
    cur_mode = mode;
    for (int i = 0; i < nf * N; i++) begin
      tries = 0;
      do begin
        step(($urandom % 100) < wr_pct, rgb(mode, i), ($urandom % 100) < rd_pct, acc);
        tries++;
      end while (!acc && tries < 2000);
      if (!acc) begin
        check("write_timeout", 0, 1);
        return;
      end
    end
  endtask
  task automatic drain();
    bit acc;
    int budget = 0;
    while (nout < pix.size() && budget < 3000) begin
      step(0, 24'h0, 1, acc);
      budget++;
    end
    check("drain_count", nout, pix.size());
    repeat (5) step(0, 24'h0, 1, acc);
    check("drain_empty", 32'(out_empty), 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    wr_inputs = 0;
    rd_output = 0;
    rst = 0;
    pix.delete();
    pmode.delete();
    nout = 0;
    #1;
    check("rst_out_empty", 32'(out_empty), 1);
    check("rst_in_full", 32'(fifo_in_gray_full), 0);
    check("rst_data_out", 32'(data_out), 0);
    repeat (2) @(negedge clk);
    rst = 1;
  endtask
  initial begin
    bit acc;
    int i;
    do_reset();
    write_frames(1, 1, 100, 100);
    drain();
    write_frames(1, 2, 100, 100);
    drain();
    write_frames(1, 3, 100, 100);
    drain();
    cur_mode = 0;
    i = 0;
    repeat (120) begin
      step(1, rgb(0, i), 0, acc);
      if (acc) i++;
    end
    check("bp_in_full", 32'(fifo_in_gray_full), 1);
    check("bp_out_nonempty", 32'(out_empty), 0);
    check("bp_stalled", 32'(i < 5 * N), 1);
    repeat (20) step(0, 24'h0, 0, acc);
    check("bp_still_full", 32'(fifo_in_gray_full), 1);
    for (int t = 0; t < 5000 && i < 5 * N; t++) begin
      step(($urandom % 100) < 80, rgb(0, i), ($urandom % 100) < 70, acc);
      if (acc) i++;
    end
    check("bp_written", i, 5 * N);
    drain();
    write_frames(0, 0, 100, 100);
    for (int t = 0; t < 7; t++) step(1, rgb(0, t), ($urandom % 2) == 1, acc);
    do_reset();
    write_frames(1, 2, 100, 100);
    drain();
    check("reset_frame_count", nout, N);
    write_frames(30, 0, 70, 60);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
